// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam int AES_NK        = 4;
  localparam int AES_MAX_ROUND = 10;

  // Round constants for round_idx 0..9 (the byte placed in the top of t).
  localparam logic [7:0] AES_RCON [AES_MAX_ROUND] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Key schedule FSM states.
  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_EMIT = 1'b1
  } key_state_e;

  // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  function automatic aes_word_t aes_rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in, one byte out, purely combinational.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y_o = SBOX[a_i];

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups, one per byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t word_i,
  output aes_word_t word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (word_i[8*b +: 8]),
      .y_o (word_o[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per valid/ready handshake.
// Optional round-key cache for reverse-order reads: define AES_KEY_CACHE_EN.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int LAST_ROUND = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam logic [3:0] LAST_IDX = 4'(LAST_ROUND);
  localparam logic [3:0] MAX_IDX  = 4'(AES_MAX_ROUND);

  key_state_e state_q, state_d;
  aes_block_t key_q,   key_d;
  logic [3:0] idx_q,   idx_d;
  logic       done_q,  done_d;

  aes_word_t  w0, w1, w2, w3;
  aes_word_t  w4, w5, w6, w7;
  aes_word_t  sub_w, temp_w;
  logic [7:0] rcon_b;
  aes_block_t next_key;
  logic       hs;

  // Next round key, combinational from the key register.
  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  aes_sub_word u_sub_word (
    .word_i (aes_rot_word(w3)),
    .word_o (sub_w)
  );

  // The final index has no successor; keep rcon defined there anyway.
  assign rcon_b   = (idx_q < MAX_IDX) ? AES_RCON[idx_q] : 8'h00;
  assign temp_w   = sub_w ^ {rcon_b, 24'h000000};
  assign w4       = w0 ^ temp_w;
  assign w5       = w1 ^ w4;
  assign w6       = w2 ^ w5;
  assign w7       = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};

  assign hs = (state_q == KS_EMIT) && rk_ready;

  // Next-state logic: start acceptance, key advance and done generation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      KS_IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          state_d = KS_EMIT;
        end
      end
      KS_EMIT: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = KS_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = next_key;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  // State, key register, index counter and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= KS_IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid  = (state_q == KS_EMIT);
  assign busy      = (state_q == KS_EMIT);
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign done      = done_q;

`ifdef AES_KEY_CACHE_EN
  aes_block_t cache_q [AES_MAX_ROUND+1];

  // Capture each round key as it is handed off.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this small array is cleared on reset so stale keys never read back after a reset.
    if (rst) begin
      for (int i = 0; i <= AES_MAX_ROUND; i++) cache_q[i] <= '0;
    end else if (hs) begin
      cache_q[idx_q] <= key_q;
    end
  end

  assign rd_key = (rd_idx <= MAX_IDX) ? cache_q[rd_idx] : '0;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: an independent FIPS-197 key
// expansion model (S-box derived from GF(2^8) inversion) plus directed tests.
module tb_aes_key_expand;

  localparam int LR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_C    = 128'hffeeddccbbaa99887766554433221100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int n_checks = 0;
  int n_bad    = 0;

  logic [7:0]   m_sbox [256];
  logic [127:0] exp_rk [LR+1];

  always #5 clk = ~clk;

  aes_key_expand #(.LAST_ROUND(LR)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= LR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- compare process ----------------
  int           exp_idx   = 0;
  logic         exp_done  = 1'b0;
  logic         stalled   = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      exp_idx  = 0;
      exp_done = 1'b0;
      stalled  = 1'b0;
    end else begin
      check("done_pulse", done, exp_done);
      if (done) check("busy_in_done", busy, 0);
      check("busy_eq_valid", busy, rk_valid);
      exp_done = 1'b0;
      if (rk_valid) begin
        if (exp_idx > LR) begin
          check("idx_overrun", 128'(exp_idx), 128'(LR));
        end else begin
          check("round_idx", round_idx, 128'(exp_idx));
          check("round_key", round_key, exp_rk[exp_idx]);
        end
        if (stalled) begin
          check("stall_key", round_key, prev_key);
          check("stall_idx", round_idx, prev_idx);
        end
        prev_key = round_key;
        prev_idx = round_idx;
        stalled  = !rk_ready;
        if (rk_ready) begin
          if (exp_idx == LR) exp_done = 1'b1;
          exp_idx++;
        end
      end else begin
        exp_idx = 0;
        stalled = 1'b0;
      end
`ifndef AES_KEY_CACHE_EN
      check("rd_key_zero", rd_key, 0);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
`ifndef AES_KEY_CACHE_EN
    rd_idx = 4'($urandom_range(0, 15));
`endif
  endtask

  task automatic start_key(input logic [127:0] k);
    for (int c = 0; c < 100 && busy; c++) tick();
    check("idle_wait", busy, 0);
    load_model(k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("first_valid", rk_valid, 1);
    check("first_idx", round_idx, 0);
  endtask

  task automatic run_to_done(input bit rand_ready, output int vcycles);
    bit got;
    got     = 1'b0;
    vcycles = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (done) got = 1'b1;
      else begin
        if (rk_valid) vcycles++;
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
      end
    end
    check("done_seen", got, 1);
    rk_ready = 1'b1;
  endtask

  initial begin
    int  vc;
    bit  seen4, got;
    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b1;
    rd_idx   = 4'd0;

    build_sbox();
    // Model pinned against published vectors.
    check("model_sbox_00", m_sbox[0], 8'h63);
    check("model_sbox_53", m_sbox[8'h53], 8'hed);
    load_model(FIPS_KEY);
    check("model_fips_0", exp_rk[0], FIPS_KEY);
    check("model_fips_1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_fips_10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    load_model('0);
    check("model_zero_1", exp_rk[1], 128'h62636363626363636263636362636363);
    check("model_zero_10", exp_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rk_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_key", round_key, 0);
    check("rst_idx", round_idx, 0);
    check("rst_rd_key", rd_key, 0);
    rst = 1'b0;
    tick();

    // FIPS key, rk_ready held high.
    start_key(FIPS_KEY);
    run_to_done(1'b0, vc);
    check("fips_valid_cycles", 128'(vc), 128'(LR + 1));
`ifdef AES_KEY_CACHE_EN
    rd_idx = 4'd10; #1;
    check("cache_10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_idx = 4'd0; #1;
    check("cache_0", rd_key, FIPS_KEY);
    rd_idx = 4'd15; #1;
    check("cache_15", rd_key, 0);
    rd_idx = 4'd5; #1;
    check("cache_5", rd_key, exp_rk[5]);
`endif

    // All-zero key.
    start_key('0);
    run_to_done(1'b0, vc);
    check("zero_valid_cycles", 128'(vc), 128'(LR + 1));

    // Backpressure with random rk_ready.
    start_key(FIPS_KEY);
    run_to_done(1'b1, vc);

    // Start while busy: ignored at idx 4 and at the final handshake; accepted in the done cycle.
    start_key(FIPS_KEY);
    seen4 = 1'b0;
    got   = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (done) begin
        load_model(KEY_C);
        key_in = KEY_C;
        start  = 1'b1;
        got    = 1'b1;
      end else if (rk_valid && round_idx == 4'd4 && !seen4) begin
        key_in = KEY_B;
        start  = 1'b1;
        seen4  = 1'b1;
      end else if (rk_valid && round_idx == 4'(LR)) begin
        key_in = KEY_B;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("busy_start_done", got, 1);
    check("done_cycle_start_valid", rk_valid, 1);
    check("done_cycle_start_key", round_key, KEY_C);
    run_to_done(1'b0, vc);
    check("keyc_valid_cycles", 128'(vc), 128'(LR + 1));

    // Reset in the middle of an expansion.
    start_key(FIPS_KEY);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (rk_valid && round_idx == 4'd6) got = 1'b1;
      else tick();
    end
    check("reach_idx6", got, 1);
    rd_idx = 4'd10;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", rk_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_key", round_key, 0);
    check("mid_rst_idx", round_idx, 0);
    check("mid_rst_rd_key", rd_key, 0);
    tick();
    rst = 1'b0;
    tick();
    start_key(FIPS_KEY);
    run_to_done(1'b0, vc);
    check("restart_valid_cycles", 128'(vc), 128'(LR + 1));
    tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule. It accepts a 128-bit cipher key with a start pulse and emits round keys 0..LAST_ROUND, one per accepted handshake, under valid/ready flow control. SubWord is computed with four `aes_sbox` instances. It sits beside the round datapath and feeds its AddRoundKey stage.

## Interface
- `LAST_ROUND`, default 10: index of the final round key emitted. Legal range 1..10; values below 10 give a reduced-round schedule for test.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin expansion of `key_in`. Sampled only when `busy`=0.
- `key_in`  in  128: cipher key, byte 0 in bits [127:120]. Sampled on an accepted `start`.
- `rk_valid`  out  1: `round_key` and `round_idx` are valid.
- `rk_ready`  in  1: consumer accepts the current round key.
- `round_key`  out  128: current round key, words w[4i]..w[4i+3], w[4i] in [127:96].
- `round_idx`  out  4: index i of `round_key`.
- `busy`  out  1: expansion in progress.
- `done`  out  1: one-cycle pulse after round key LAST_ROUND is accepted.
- `rd_idx`  in  4: cache read index (see Configuration).
- `rd_key`  out  128: cache read data.

## Operation
- States:
  - IDLE: `busy`=0, `rk_valid`=0. An accepted `start` loads `key_in` into the key register, clears `round_idx`, and moves to EMIT.
  - EMIT: `busy`=1, `rk_valid`=1. The key register drives `round_key`.
    - On `rk_valid`&`rk_ready` with `round_idx`<LAST_ROUND: register the next key, increment `round_idx`, stay in EMIT.
    - On handshake with `round_idx`==LAST_ROUND: go to IDLE and assert `done` next cycle.
- Next key, combinational from the current key (w0..w3):
  - t = SubWord(RotWord(w3)) ^ {rcon[round_idx], 24'h0}
  - w4 = w0^t, w5 = w1^w4, w6 = w2^w5, w7 = w3^w6.
- RotWord rotates bytes left by one: {b0,b1,b2,b3} becomes {b1,b2,b3,b0}.
- rcon for round_idx 0..9: 01,02,04,08,10,20,40,80,1b,36.
- Outputs are held stable while `rk_valid`=1 and `rk_ready`=0.
- `start` while `busy`=1 is ignored, including in the cycle of the final handshake.
- Reset, including mid-expansion:
  - State goes to IDLE.
  - `rk_valid`, `busy`, `done` go to 0.
  - `round_key` goes to 0 and `round_idx` goes to 0.
  - `rd_key` goes to 0 and the cache is cleared.

## Timing
- `start` at edge N puts round key 0 on the outputs with `rk_valid`=1 after edge N.
- Each accepted handshake produces the next key one cycle later. With `rk_ready` held at 1, keys appear on LAST_ROUND+1 consecutive cycles.
- `done` is high for the single cycle after the final handshake, with `busy`=0 in that same cycle.
- A new `start` is accepted in the `done` cycle.
- The combinational path is one key register → 4× `aes_sbox` → XOR chain → key register.

## Configuration
- `AES_KEY_CACHE_EN` defined:
  - An 11×128 register array captures every round key at its handshake.
  - `rd_key` = cache[`rd_idx`], combinational. It is valid once the key for that index has been accepted.
  - `rd_idx`>10 returns 0.
  - This supports the reverse key order needed by decryption.
- Not defined:
  - No array is built.
  - `rd_key` is tied to 0 and `rd_idx` is unused.
  - The ports remain present in both builds.

## Structure
- `aes_pkg` holds:
  - typedefs `aes_word_t` (32b) and `aes_block_t` (128b);
  - constant `AES_NK`=4;
  - constant `AES_MAX_ROUND`=10;
  - the `AES_RCON` array.
- Sub-module `aes_sub_word` wraps four existing `aes_sbox` instances, mapping 32 bits in to 32 bits out.
- The top-level module holds the FSM, the key register, the index counter and the optional cache.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - idx0 = the key;
  - idx1 = a0fafe1788542cb123a339392a6c7605;
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - 11 consecutive valid cycles, then one `done` pulse.
- All-zero key:
  - idx1 = 62636363626363636263636362636363;
  - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure:
  - drive random `rk_ready` with ~50% low;
  - `round_key` and `round_idx` must stay stable while stalled;
  - the key sequence must be identical to the `rk_ready`=1 run.
- Start while busy:
  - pulse `start` with a different key at idx 4 and in the final-handshake cycle;
  - both are ignored;
  - a start in the `done` cycle is accepted.
- Reset mid-run:
  - assert `rst` at idx 6;
  - all outputs go to 0 immediately (async);
  - a restart reproduces idx0..10 correctly.
- With `AES_KEY_CACHE_EN`, after the FIPS run:
  - `rd_idx`=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `rd_idx`=0 gives the key;
  - `rd_idx`=15 gives 0.
- Without the macro, `rd_key` stays 0 throughout.
